// File: rtl/display_scan_pkg.sv
// display_scan_pkg: segment codes, nibble markers and frame states shared by the scan capture
package display_scan_pkg;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_6_ALT = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_7_ALT = 7'b0100111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_9_ALT = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [3:0] NIB_BLANK = 4'hF;
  localparam logic [3:0] NIB_ERR   = 4'hE;
  typedef enum logic {HUNT, COLLECT} state_e;
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: active-high {g..a} pattern to BCD nibble with blank and error flags
module seg7_to_bcd
  import display_scan_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);
  always_comb begin
    nibble = NIB_ERR;
    blank = 1'b0;
    err = 1'b0;
    case (pattern)
      SEG_0: nibble = 4'd0;
      SEG_1: nibble = 4'd1;
      SEG_2: nibble = 4'd2;
      SEG_3: nibble = 4'd3;
      SEG_4: nibble = 4'd4;
      SEG_5: nibble = 4'd5;
      SEG_6, SEG_6_ALT: nibble = 4'd6;
      SEG_7, SEG_7_ALT: nibble = 4'd7;
      SEG_8: nibble = 4'd8;
      SEG_9, SEG_9_ALT: nibble = 4'd9;
      SEG_BLANK: begin
        nibble = NIB_BLANK;
        blank = 1'b1;
      end
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/display_scan_capture.sv
// display_scan_capture: rebuilds the 4-digit frame shown on a multiplexed 7-segment bus
module display_scan_capture
  import display_scan_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  dig_i,
  output logic [15:0] frame_o,
  output logic [3:0]  blank_o,
  output logic        frame_valid_o,
  output logic        frame_changed_o,
  output logic        pattern_err_o,
  output logic        seq_err_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [6:0] SEG_IDLE = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0] DIG_IDLE = {4{DIG_ACTIVE_LOW}};
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [6:0] seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, pat_q, pat_d, seg_n;
  logic [3:0] dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d, dig_n;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d, exp_idx_q, exp_idx_d, idx;
  logic armed_q, armed_d, ovl_q, ovl_d;
  state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] shadow_nib_q, shadow_nib_d, frame_q, frame_d;
  logic [3:0] shadow_blank_q, shadow_blank_d, blank_q, blank_d;
  logic frame_valid_q, frame_valid_d, frame_changed_q, frame_changed_d;
  logic pattern_err_q, pattern_err_d, seq_err_q, seq_err_d;
  logic idle, one_hot, overlap, same, accept, store, seq_bad;
  logic [3:0] acc_nib;
  logic acc_blank, acc_err;
  seg7_to_bcd u_dec (
    .pattern(pat_q),
    .nibble (acc_nib),
    .blank  (acc_blank),
    .err    (acc_err)
  );
  always_comb begin
    seg_s1_d = seg_i;
    seg_s2_d = seg_s1_q;
    dig_s1_d = dig_i;
    dig_s2_d = dig_s1_q;
    seg_n = seg_s2_q ^ SEG_IDLE;
    dig_n = dig_s2_q ^ DIG_IDLE;
    idle = dig_n == 4'b0;
    one_hot = !idle && (dig_n & (dig_n - 4'd1)) == 4'b0;
    overlap = !idle && !one_hot;
    idx = dig_n[3] ? 2'd0 : dig_n[2] ? 2'd1 : dig_n[1] ? 2'd2 : 2'd3;
    // idx_q/pat_q hold the previous one-hot sample; cnt_q counts how long it has held
    accept = armed_q && cnt_q == STABLE;
    same = cnt_q != 8'd0 && idx == idx_q && seg_n == pat_q;
    cnt_d = !one_hot ? 8'd0 : !same ? 8'd1 : cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
    idx_d = one_hot ? idx : idx_q;
    pat_d = one_hot ? seg_n : pat_q;
    armed_d = idle || (one_hot && idx != idx_q) || (armed_q && !accept);
    ovl_d = overlap;
    state_d = state_q;
    exp_idx_d = exp_idx_q;
    tmo_d = '0;
    shadow_nib_d = shadow_nib_q;
    shadow_blank_d = shadow_blank_q;
    frame_d = frame_q;
    blank_d = blank_q;
    store = 1'b0;
    seq_bad = 1'b0;
    if (state_q == HUNT) begin
      if (accept && idx_q == 2'd0) begin
        store = 1'b1;
        exp_idx_d = 2'd1;
        state_d = COLLECT;
      end
    end else if (accept) begin
      if (idx_q == exp_idx_q) begin
        store = 1'b1;
        exp_idx_d = exp_idx_q + 2'd1;
      end else begin
        seq_bad = 1'b1;
        store = idx_q == 2'd0;
        exp_idx_d = 2'd1;
        state_d = idx_q == 2'd0 ? COLLECT : HUNT;
      end
    end else begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_q == TMO_LAST) begin
        seq_bad = 1'b1;
        state_d = HUNT;
      end
    end
    if (store) begin
      shadow_nib_d[{~idx_q, 2'b00} +: 4] = acc_nib;
      shadow_blank_d[~idx_q] = acc_blank;
    end
    frame_valid_d = store && idx_q == 2'd3;
    frame_changed_d = frame_valid_d && shadow_nib_d != frame_q;
    if (frame_valid_d) begin
      frame_d = shadow_nib_d;
      blank_d = shadow_blank_d;
    end
    pattern_err_d = accept && acc_err;
    seq_err_d = seq_bad || (overlap && !ovl_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1_q <= SEG_IDLE;
      seg_s2_q <= SEG_IDLE;
      dig_s1_q <= DIG_IDLE;
      dig_s2_q <= DIG_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      pat_q <= '0;
      armed_q <= 1'b1;
      ovl_q <= 1'b0;
      state_q <= HUNT;
      exp_idx_q <= '0;
      tmo_q <= '0;
      shadow_nib_q <= 16'hFFFF;
      shadow_blank_q <= 4'b1111;
      frame_q <= 16'hFFFF;
      blank_q <= 4'b1111;
      frame_valid_q <= 1'b0;
      frame_changed_q <= 1'b0;
      pattern_err_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      seg_s1_q <= seg_s1_d;
      seg_s2_q <= seg_s2_d;
      dig_s1_q <= dig_s1_d;
      dig_s2_q <= dig_s2_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pat_q <= pat_d;
      armed_q <= armed_d;
      ovl_q <= ovl_d;
      state_q <= state_d;
      exp_idx_q <= exp_idx_d;
      tmo_q <= tmo_d;
      shadow_nib_q <= shadow_nib_d;
      shadow_blank_q <= shadow_blank_d;
      frame_q <= frame_d;
      blank_q <= blank_d;
      frame_valid_q <= frame_valid_d;
      frame_changed_q <= frame_changed_d;
      pattern_err_q <= pattern_err_d;
      seq_err_q <= seq_err_d;
    end
  end
  assign frame_o = frame_q;
  assign blank_o = blank_q;
  assign frame_valid_o = frame_valid_q;
  assign frame_changed_o = frame_changed_q;
  assign pattern_err_o = pattern_err_q;
  assign seq_err_o = seq_err_q;
endmodule
